// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and one-access sequencer for the single-ported data memory.
// Memory controls are driven from registers only; responses are registered and held until accepted.
module dmem_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [5:0]        req_funct3,
  input  logic [2*XLEN-1:0] req_addr,
  input  logic [2*XLEN-1:0] req_wdata,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              sel_c;
  logic              sel_we_c;
  logic [2:0]        sel_f3_c;
  logic [XLEN-1:0]   sel_addr_c;
  logic [XLEN-1:0]   sel_wdata_c;

  // Funct3 set, natural alignment and word-index range check.
  function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                    input logic [XLEN-1:0] a);
    logic f3_ok, misaligned, out_of_range;
    f3_ok        = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                      : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)) ||
                   ((f3[1:0] == 2'b01) && a[0]);
    out_of_range = (a >> 2) >= XLEN'(MEM_SIZE);
    return f3_ok && !misaligned && !out_of_range;
  endfunction

  // Winner: a lone requester, otherwise whoever was not granted last.
  always_comb begin
    sel_c = 1'b0;
    case (req_valid)
      2'b10:   sel_c = 1'b1;
      2'b11:   sel_c = ~last_grant_q;
      default: sel_c = 1'b0;
    endcase
    sel_we_c    = sel_c ? req_we[1]                 : req_we[0];
    sel_f3_c    = sel_c ? req_funct3[5:3]           : req_funct3[2:0];
    sel_addr_c  = sel_c ? req_addr[2*XLEN-1:XLEN]   : req_addr[XLEN-1:0];
    sel_wdata_c = sel_c ? req_wdata[2*XLEN-1:XLEN]  : req_wdata[XLEN-1:0];
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready    = 2'b00;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[sel_c] = 1'b1;
          owner_d          = sel_c;
          last_grant_d     = sel_c;
          we_d             = sel_we_c;
          funct3_d         = sel_f3_c;
          addr_d           = sel_addr_c;
          wdata_d          = sel_wdata_c;
          if (is_legal(sel_we_c, sel_f3_c, sel_addr_c)) begin
            state_d  = ACCESS;
            mem_en_d = 1'b1;
            mem_we_d = sel_we_c;
          end else begin
            state_d            = RESP;
            rsp_valid_d[sel_c] = 1'b1;
            err_d              = 1'b1;
            rdata_d            = '0;
          end
        end
      end
      ACCESS: begin
        state_d              = RESP;
        rsp_valid_d[owner_q] = 1'b1;
        err_d                = 1'b0;
        rdata_d              = we_q ? '0 : mem_rdata;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d     = IDLE;
          rsp_valid_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      rsp_valid_q  <= rsp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_funct3 = funct3_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;

endmodule
